// File: rtl/cpu_trap_unit_if.sv
// rtl/cpu_trap_unit_if.sv - event, CSR and redirect signals between the pipeline and the trap unit
interface cpu_trap_unit_if;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        retire_valid;
  logic [31:0] retire_next_pc;
  logic        irq_timer;
  logic        irq_ext;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wenable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  modport slave (
    input  exc_valid, exc_cause, exc_pc, mret_valid, retire_valid, retire_next_pc,
           irq_timer, irq_ext, mie, mtvec, mepc,
    output csr_waddr, csr_wdata, csr_wenable, redirect_valid, redirect_pc, flush, busy
  );

  modport master (
    output exc_valid, exc_cause, exc_pc, mret_valid, retire_valid, retire_next_pc,
           irq_timer, irq_ext, mie, mtvec, mepc,
    input  csr_waddr, csr_wdata, csr_wenable, redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/cpu_trap_unit.sv
// rtl/cpu_trap_unit.sv - machine-mode trap entry/return sequencer (mepc, mcause, redirect)
module cpu_trap_unit #(
  parameter int TIMER_CAUSE = 7,
  parameter int EXT_CAUSE   = 11
) (
  input logic             clk,
  input logic             rst,
  cpu_trap_unit_if.slave  t
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_MEPC   = 3'd1;
  localparam logic [2:0] WR_MCAUSE = 3'd2;
  localparam logic [2:0] REDIRECT  = 3'd3;
  localparam logic [2:0] MRET      = 3'd4;

  localparam logic [4:0] TIMER_CODE = 5'(TIMER_CAUSE);
  localparam logic [4:0] EXT_CODE   = 5'(EXT_CAUSE);

  logic [2:0]  state;
  logic        in_handler;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;

  logic        ext_pend;
  logic        timer_pend;
  logic        idle_live;
  logic        take_exc;
  logic        take_mret;
  logic        take_irq;
  logic        accept;
  logic [4:0]  irq_code;
  logic [31:0] vec_base;

  always_comb begin
    ext_pend   = t.irq_ext & t.mie[EXT_CAUSE];
    timer_pend = t.irq_timer & t.mie[TIMER_CAUSE];
    idle_live  = (state == IDLE) & ~rst;
    take_exc   = idle_live & t.exc_valid;
    take_mret  = idle_live & ~t.exc_valid & t.mret_valid;
    take_irq   = idle_live & ~t.exc_valid & ~t.mret_valid &
                 (ext_pend | timer_pend) & t.retire_valid & ~in_handler;
    accept     = take_exc | take_mret | take_irq;
    irq_code   = ext_pend ? EXT_CODE : TIMER_CODE;
    vec_base   = {t.mtvec[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_handler <= 1'b0;
      trap_pc    <= 32'd0;
      trap_cause <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_exc) begin
            trap_pc    <= t.exc_pc;
            trap_cause <= {1'b0, 26'd0, t.exc_cause};
            state      <= WR_MEPC;
          end else if (take_mret) begin
            state      <= MRET;
          end else if (take_irq) begin
            trap_pc    <= t.retire_next_pc;
            trap_cause <= {1'b1, 26'd0, irq_code};
            state      <= WR_MEPC;
          end
        end
        WR_MEPC:   state <= WR_MCAUSE;
        WR_MCAUSE: state <= REDIRECT;
        REDIRECT: begin
          in_handler <= 1'b1;
          state      <= IDLE;
        end
        MRET: begin
          in_handler <= 1'b0;
          state      <= IDLE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet during reset so an aborted sequence never leaks a write or redirect.
  always_comb begin
    t.csr_wenable    = 1'b0;
    t.csr_waddr      = 12'd0;
    t.csr_wdata      = 32'd0;
    t.redirect_valid = 1'b0;
    t.redirect_pc    = 32'd0;
    t.flush          = 1'b0;
    t.busy           = 1'b0;
    if (!rst) begin
      t.flush = accept;
      t.busy  = (state != IDLE) | accept;
      case (state)
        WR_MEPC: begin
          t.csr_wenable = 1'b1;
          t.csr_waddr   = 12'h341;
          t.csr_wdata   = trap_pc;
        end
        WR_MCAUSE: begin
          t.csr_wenable = 1'b1;
          t.csr_waddr   = 12'h342;
          t.csr_wdata   = trap_cause;
        end
        REDIRECT: begin
          t.redirect_valid = 1'b1;
          t.redirect_pc    = vec_base +
            ((t.mtvec[1:0] == 2'b01 && trap_cause[31]) ? {25'd0, trap_cause[4:0], 2'b00} : 32'd0);
        end
        MRET: begin
          t.redirect_valid = 1'b1;
          t.redirect_pc    = t.mepc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_trap_unit.md
CPU_TRAP_UNIT -- requirements
Module: cpu_trap_unit

Interface
REQ-001 SHALL have parameter TIMER_CAUSE, default 7, meaning mcause code and mie bit index for the timer interrupt.
REQ-002 SHALL have parameter EXT_CAUSE, default 11, meaning mcause code and mie bit index for the external interrupt.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk, rst.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 exc_valid  input  1  synchronous exception at writeback stage.
REQ-007 exc_cause  input  5  exception code.
REQ-008 exc_pc  input  32  PC of the faulting instruction.
REQ-009 mret_valid  input  1  mret at writeback stage.
REQ-010 retire_valid  input  1  instruction retiring this cycle (non-bubble writeback).
REQ-011 retire_next_pc  input  32  PC following the retiring instruction.
REQ-012 irq_timer, irq_ext  input  1 each  level interrupt requests.
REQ-013 mie  input  32  current mie CSR value.
REQ-014 mtvec  input  32  current mtvec CSR value.
REQ-015 mepc  input  32  current mepc CSR value.
REQ-016 csr_waddr / csr_wdata / csr_wenable  output  12/32/1  CSR write port into the CSR file.
REQ-017 redirect_valid / redirect_pc  output  1/32  fetch redirect.
REQ-018 flush  output  1  kill all younger pipeline instructions.
REQ-019 busy  output  1  trap sequence in progress; pipeline stalls.

Function
REQ-020 SHALL implement FSM states IDLE, WR_MEPC, WR_MCAUSE, REDIRECT, MRET.
REQ-021 In IDLE, event priority SHALL be exc_valid > mret_valid > external IRQ > timer IRQ.
REQ-022 IRQ pending SHALL mean irq_ext&mie[EXT_CAUSE] or irq_timer&mie[TIMER_CAUSE]; it SHALL be taken only when retire_valid=1 and in_handler=0.
REQ-023 On acceptance, the block SHALL latch trap_pc and trap_cause, assert flush for that cycle only, and move to WR_MEPC (trap) or MRET (mret).
REQ-024 trap_pc SHALL be exc_pc for exceptions and retire_next_pc for interrupts.
REQ-025 trap_cause SHALL be {1'b0,26'b0,exc_cause} for exceptions and {1'b1,26'b0,code[4:0]} for interrupts.
REQ-026 WR_MEPC SHALL drive csr_wenable=1, csr_waddr=12'h341, csr_wdata=trap_pc for exactly one cycle.
REQ-027 WR_MCAUSE SHALL drive csr_wenable=1, csr_waddr=12'h342, csr_wdata=trap_cause for exactly one cycle.
REQ-028 REDIRECT SHALL assert redirect_valid for one cycle and set in_handler=1.
REQ-029 In REDIRECT, redirect_pc SHALL be {mtvec[31:2],2'b00}+4*code if mtvec[1:0]=2'b01 and the trap is an interrupt; otherwise {mtvec[31:2],2'b00}.
REQ-030 Vectored address arithmetic SHALL be 32-bit modulo (wraps silently).
REQ-031 MRET SHALL assert redirect_valid with redirect_pc=mepc for one cycle, clear in_handler, and return to IDLE.
REQ-032 busy SHALL be 1 in every non-IDLE state and in the acceptance cycle.
REQ-033 All event inputs SHALL be ignored while not IDLE.
REQ-034 Trap latency SHALL be: accept at cycle N, mepc write at N+1, mcause write at N+2, redirect at N+3, then IDLE at N+4.
REQ-035 Mret latency SHALL be: accept at cycle N, redirect at N+1, then IDLE at N+2.
REQ-036 An exception while in_handler=1 SHALL still be taken.
REQ-037 Interrupts SHALL stay masked while in_handler=1.
REQ-038 csr_wenable and redirect_valid SHALL never both be 1 in the same cycle.
REQ-039 csr_waddr and csr_wdata SHALL be 0 whenever csr_wenable=0.

Reset
REQ-040 While rst=1 at a clock edge, state SHALL become IDLE and in_handler=0, including mid-sequence.
REQ-041 In the cycle after reset, outputs SHALL be: csr_wenable=0, csr_waddr=0, csr_wdata=0, redirect_valid=0, redirect_pc=0, flush=0, busy=0.

Verification
REQ-042 Exception: exc_valid, cause 2, pc 0x100, mtvec 0x8000_0001 -> flush at N; mepc write 0x100 at N+1; mcause write 0x2 at N+2; redirect 0x8000_0000 at N+3.
REQ-043 Vectored IRQ: irq_ext=1, mie[11]=1, retire_valid, retire_next_pc 0x204, mtvec 0x8000_0001 -> mepc 0x204, mcause 0x8000_000B, redirect 0x8000_002C.
REQ-044 Priority: exc_valid, mret_valid, and irq_timer with mie[7]=1 all in one cycle -> exception sequence only; mret and IRQ are dropped.
REQ-045 Masking: after a trap (in_handler=1), irq_timer held -> no trap; mret with mepc 0x300 -> redirect 0x300 at N+1; on the next retire, timer trap is taken.
REQ-046 Reset: rst pulsed in WR_MCAUSE -> no mcause write, no redirect, busy=0, and a later IRQ is taken.
